motor_pwm_ctrl: RTL and testbench

- Drive-motor PWM stage clocked from the rover's 100 MHz system clock domain produced by the clock generator.
- Accepts signed speed commands and slew-limits them.
- Inserts a dead interval on direction reversal and generates PWM/DIR for one H-bridge channel.
- A command watchdog forces the motor to stop if the command source goes silent.

---
 rtl/motor_pwm_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_motor_pwm_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_pwm_ctrl.sv
// Single-channel H-bridge PWM stage: slew-limited signed speed, reversal
// dead interval and a command-silence watchdog.
module motor_pwm_ctrl #(
  parameter int unsigned SYSCLK_FREQ      = 100_000_000,
  parameter int unsigned PWM_FREQ         = 20_000,
  parameter int unsigned CMD_W            = 8,
  parameter int unsigned RAMP_STEP        = 4,
  parameter int unsigned RAMP_PERIODS     = 1,
  parameter int unsigned DEADTIME_PERIODS = 2,
  parameter int unsigned TIMEOUT_CYC      = 50_000_000
) (
  input  logic                    clk_100M,
  input  logic                    sysrstn,
  input  logic                    enable,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic signed [CMD_W-1:0] cmd_speed,
  output logic                    pwm_out,
  output logic                    dir_out,
  output logic signed [CMD_W-1:0] duty_cur,
  output logic                    timeout
);

  localparam int unsigned PERIOD = SYSCLK_FREQ / PWM_FREQ;
  localparam int unsigned CNT_W  = $clog2(PERIOD);
  localparam int unsigned PROD_W = CMD_W + CNT_W + 1;
  localparam int unsigned RP_W   = $clog2(RAMP_PERIODS + 1);
  localparam int unsigned DEAD_W = $clog2(DEADTIME_PERIODS + 1);
  localparam int unsigned WD_W   = $clog2(TIMEOUT_CYC + 1);

  localparam logic signed [CMD_W-1:0] ZERO      = '0;
  localparam logic signed [CMD_W-1:0] CMD_MIN   = {1'b1, {(CMD_W-1){1'b0}}};
  localparam logic signed [CMD_W-1:0] CMD_CLAMP = {1'b1, {(CMD_W-2){1'b0}}, 1'b1};
  localparam logic signed [CMD_W:0]   STEP_S    = (CMD_W+1)'(RAMP_STEP);

  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

  state_t                  state, state_nx;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        compare;
  logic [RP_W-1:0]         rp_cnt;
  logic [DEAD_W-1:0]       dead_cnt, dead_nx;
  logic [WD_W-1:0]         wd_cnt;
  logic signed [CMD_W-1:0] target;
  logic signed [CMD_W-1:0] duty_nx;
  logic                    dir_nx;
  logic                    boundary_c, ramp_tick_c, accept_c;
  logic signed [CMD_W-1:0] eff_c;
  logic                    same_dir_c, opposite_c;
  logic [CMD_W-1:0]        mag_c;
  logic [PROD_W-1:0]       prod_c;

  // Move cur toward tgt by at most RAMP_STEP without overshoot.
  function automatic logic signed [CMD_W-1:0] step_toward(
    input logic signed [CMD_W-1:0] cur,
    input logic signed [CMD_W-1:0] tgt
  );
    logic signed [CMD_W:0] diff;
    diff = $signed({tgt[CMD_W-1], tgt}) - $signed({cur[CMD_W-1], cur});
    if (diff > STEP_S)       return cur + CMD_W'(RAMP_STEP);
    else if (diff < -STEP_S) return cur - CMD_W'(RAMP_STEP);
    else                     return tgt;
  endfunction

  assign accept_c    = cmd_valid & cmd_ready;
  assign boundary_c  = (cnt == CNT_W'(PERIOD - 1));
  assign ramp_tick_c = boundary_c && (rp_cnt == RP_W'(RAMP_PERIODS - 1));
  assign eff_c       = timeout ? ZERO : target;
  assign same_dir_c  = (eff_c != ZERO) && ((eff_c < ZERO) == dir_out);
  assign opposite_c  = (eff_c != ZERO) && ((eff_c < ZERO) != dir_out);
  assign mag_c       = duty_nx[CMD_W-1] ? CMD_W'(-duty_nx) : CMD_W'(duty_nx);
  assign prod_c      = PROD_W'(mag_c) * PROD_W'(PERIOD);

  // PWM period counter and ramp-period divider.
  always_ff @(posedge clk_100M or negedge sysrstn) begin
    if (!sysrstn) begin
      cnt    <= '0;
      rp_cnt <= '0;
    end else if (boundary_c) begin
      cnt    <= '0;
      rp_cnt <= ramp_tick_c ? '0 : rp_cnt + RP_W'(1);
    end else begin
      cnt    <= cnt + CNT_W'(1);
    end
  end

  // Command acceptance; most-negative code folds to symmetric range.
  always_ff @(posedge clk_100M or negedge sysrstn) begin
    if (!sysrstn) begin
      cmd_ready <= 1'b1;
      target    <= '0;
    end else begin
      cmd_ready <= 1'b1;
      if (accept_c && enable)
        target <= (cmd_speed == CMD_MIN) ? CMD_CLAMP : cmd_speed;
    end
  end

  // Watchdog: saturating silence counter.
  always_ff @(posedge clk_100M or negedge sysrstn) begin
    if (!sysrstn) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else if (accept_c) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else if (wd_cnt != WD_W'(TIMEOUT_CYC)) begin
      wd_cnt <= wd_cnt + WD_W'(1);
      if (wd_cnt + WD_W'(1) == WD_W'(TIMEOUT_CYC)) timeout <= 1'b1;
    end
  end

  // Control state register.
  always_ff @(posedge clk_100M or negedge sysrstn) begin
    if (!sysrstn) begin
      state    <= IDLE;
      duty_cur <= '0;
      dir_out  <= 1'b0;
      dead_cnt <= '0;
    end else begin
      state    <= state_nx;
      duty_cur <= duty_nx;
      dir_out  <= dir_nx;
      dead_cnt <= dead_nx;
    end
  end

  // Next-state: ramp at ramp ticks, count dead periods at boundaries.
  always_comb begin
    state_nx = state;
    duty_nx  = duty_cur;
    dir_nx   = dir_out;
    dead_nx  = dead_cnt;
    if (!enable) begin
      state_nx = IDLE;
      duty_nx  = ZERO;
      dead_nx  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (ramp_tick_c && same_dir_c) begin
            state_nx = RUN;
            duty_nx  = step_toward(duty_cur, eff_c);
          end else if (ramp_tick_c && opposite_c) begin
            state_nx = DEAD;
            dead_nx  = '0;
          end
        end
        RUN: begin
          if (ramp_tick_c) begin
            duty_nx = step_toward(duty_cur, same_dir_c ? eff_c : ZERO);
            if (duty_nx == ZERO) begin
              state_nx = opposite_c ? DEAD : IDLE;
              dead_nx  = '0;
            end
          end
        end
        DEAD: begin
          if (boundary_c) begin
            if (dead_cnt == DEAD_W'(DEADTIME_PERIODS - 1)) begin
              dir_nx   = ~dir_out;
              state_nx = IDLE;
              dead_nx  = '0;
            end else begin
              dead_nx = dead_cnt + DEAD_W'(1);
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Compare latched at the boundary from the duty entering the next period.
  always_ff @(posedge clk_100M or negedge sysrstn) begin
    if (!sysrstn)        compare <= '0;
    else if (!enable)    compare <= '0;
    else if (boundary_c) compare <= CNT_W'(prod_c >> (CMD_W - 1));
  end

  // Registered PWM output, blanked while disabled or in the dead interval.
  always_ff @(posedge clk_100M or negedge sysrstn) begin
    if (!sysrstn)                     pwm_out <= 1'b0;
    else if (!enable || state == DEAD) pwm_out <= 1'b0;
    else                              pwm_out <= (cnt < compare);
  end

endmodule

// File: tb/tb_motor_pwm_ctrl.sv
// Scoreboard bench for motor_pwm_ctrl at PERIOD=100, step 16, timeout 2000.
module tb_motor_pwm_ctrl;

  logic              clk_100M = 1'b0;
  logic              sysrstn  = 1'b0;
  logic              enable   = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic signed [7:0] cmd_speed = '0;
  logic              pwm_out;
  logic              dir_out;
  logic signed [7:0] duty_cur;
  logic              timeout;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;
  int exp_q[$];

  motor_pwm_ctrl #(
    .SYSCLK_FREQ(1_000_000), .PWM_FREQ(10_000), .CMD_W(8), .RAMP_STEP(16),
    .RAMP_PERIODS(1), .DEADTIME_PERIODS(2), .TIMEOUT_CYC(2000)
  ) dut (
    .clk_100M(clk_100M), .sysrstn(sysrstn), .enable(enable),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_speed(cmd_speed),
    .pwm_out(pwm_out), .dir_out(dir_out), .duty_cur(duty_cur), .timeout(timeout)
  );

  always #5 clk_100M = ~clk_100M;

  // Posedges since reset release; counter value after edge k is k%100.
  always @(posedge clk_100M or negedge sysrstn) begin
    if (!sysrstn) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic do_reset();
    @(negedge clk_100M);
    sysrstn = 1'b0; enable = 1'b1; cmd_valid = 1'b0; cmd_speed = '0;
    exp_q.delete();
    repeat (3) @(negedge clk_100M);
    sysrstn = 1'b1;
  endtask

  task automatic send_cmd(input int v);
    cmd_valid = 1'b1;
    cmd_speed = 8'(v);
    @(negedge clk_100M);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_duty_change(input int budget, output bit ok);
    logic signed [7:0] prev;
    prev = duty_cur;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_100M);
      if (duty_cur !== prev) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_until_cyc(input int c);
    while (cyc < c) @(negedge clk_100M);
  endtask

  task automatic count_high(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_100M);
      if (pwm_out === 1'b1) n++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk_100M);
    sysrstn = 1'b0;
    #1;
    n_tests++;
    if (pwm_out !== 1'b0 || dir_out !== 1'b0 || duty_cur !== 8'sd0 ||
        timeout !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_values: pwm=%b dir=%b duty=%0d timeout=%b ready=%b, expected 0 0 0 0 1",
               pwm_out, dir_out, duty_cur, timeout, cmd_ready);
    end
  endtask

  task automatic test_ramp_up();
    bit ok; int e; int n;
    do_reset();
    send_cmd(64);
    exp_q.push_back(16); exp_q.push_back(32); exp_q.push_back(48); exp_q.push_back(64);
    while (exp_q.size() > 0) begin
      wait_duty_change(300, ok);
      e = exp_q.pop_front();
      n_tests++;
      if (!ok || duty_cur !== 8'(e) || cyc % 100 != 0) begin
        n_fail++;
        $display("FAIL ramp_up_duty: got %0d at cyc %0d, expected %0d on a boundary", duty_cur, cyc, e);
      end
    end
    wait_until_cyc(600);
    count_high(n);
    n_tests++;
    if (n != 50 || dir_out !== 1'b0) begin
      n_fail++;
      $display("FAIL ramp_up_pwm: high=%0d dir=%b, expected 50 dir 0", n, dir_out);
    end
  endtask

  task automatic test_reversal();
    bit ok; bit bad; int e; int n;
    do_reset();
    send_cmd(32);
    exp_q.push_back(16); exp_q.push_back(32);
    while (exp_q.size() > 0) begin
      wait_duty_change(300, ok);
      e = exp_q.pop_front();
      n_tests++;
      if (!ok || duty_cur !== 8'(e) || cyc % 100 != 0) begin
        n_fail++;
        $display("FAIL rev_settle_duty: got %0d at cyc %0d, expected %0d", duty_cur, cyc, e);
      end
    end
    send_cmd(-32);
    exp_q.push_back(16); exp_q.push_back(0);
    while (exp_q.size() > 0) begin
      wait_duty_change(300, ok);
      e = exp_q.pop_front();
      n_tests++;
      if (!ok || duty_cur !== 8'(e) || cyc % 100 != 0) begin
        n_fail++;
        $display("FAIL rev_down_duty: got %0d at cyc %0d, expected %0d", duty_cur, cyc, e);
      end
    end
    bad = 1'b0;
    while (cyc < 600) begin
      if (pwm_out !== 1'b0 || dir_out !== 1'b0) bad = 1'b1;
      @(negedge clk_100M);
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL rev_dead_window: pwm/dir active during dead interval, expected pwm 0 dir 0");
    end
    n_tests++;
    if (dir_out !== 1'b1 || cyc != 600) begin
      n_fail++;
      $display("FAIL rev_dir_flip: dir=%b at cyc %0d, expected 1 at cyc 600", dir_out, cyc);
    end
    exp_q.push_back(-16); exp_q.push_back(-32);
    while (exp_q.size() > 0) begin
      wait_duty_change(300, ok);
      e = exp_q.pop_front();
      n_tests++;
      if (!ok || duty_cur !== 8'(e) || cyc % 100 != 0) begin
        n_fail++;
        $display("FAIL rev_up_duty: got %0d at cyc %0d, expected %0d", duty_cur, cyc, e);
      end
    end
    wait_until_cyc(900);
    count_high(n);
    n_tests++;
    if (n != 25 || dir_out !== 1'b1) begin
      n_fail++;
      $display("FAIL rev_pwm: high=%0d dir=%b, expected 25 dir 1", n, dir_out);
    end
  endtask

  task automatic test_clamp();
    bit ok; int e; int n;
    do_reset();
    send_cmd(-128);
    for (int k = 1; k <= 7; k++) exp_q.push_back(-16 * k);
    exp_q.push_back(-127);
    while (exp_q.size() > 0) begin
      wait_duty_change(500, ok);
      e = exp_q.pop_front();
      n_tests++;
      if (!ok || duty_cur !== 8'(e) || cyc % 100 != 0) begin
        n_fail++;
        $display("FAIL clamp_duty: got %0d at cyc %0d, expected %0d", duty_cur, cyc, e);
      end
    end
    wait_until_cyc(1200);
    count_high(n);
    n_tests++;
    if (n != 99 || dir_out !== 1'b1) begin
      n_fail++;
      $display("FAIL clamp_pwm: high=%0d dir=%b, expected 99 dir 1", n, dir_out);
    end
  endtask

  task automatic test_watchdog();
    bit ok; int e; int t_cyc;
    do_reset();
    send_cmd(48);
    exp_q.push_back(16); exp_q.push_back(32); exp_q.push_back(48);
    while (exp_q.size() > 0) begin
      wait_duty_change(300, ok);
      e = exp_q.pop_front();
      n_tests++;
      if (!ok || duty_cur !== 8'(e)) begin
        n_fail++;
        $display("FAIL wd_up_duty: got %0d at cyc %0d, expected %0d", duty_cur, cyc, e);
      end
    end
    t_cyc = -1;
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk_100M);
      if (timeout === 1'b1) begin t_cyc = cyc; break; end
    end
    n_tests++;
    if (t_cyc != 2001) begin
      n_fail++;
      $display("FAIL wd_trip_time: timeout rose at cyc %0d, expected 2001", t_cyc);
    end
    exp_q.push_back(32); exp_q.push_back(16); exp_q.push_back(0);
    while (exp_q.size() > 0) begin
      wait_duty_change(300, ok);
      e = exp_q.pop_front();
      n_tests++;
      if (!ok || duty_cur !== 8'(e) || cyc % 100 != 0) begin
        n_fail++;
        $display("FAIL wd_down_duty: got %0d at cyc %0d, expected %0d", duty_cur, cyc, e);
      end
    end
    send_cmd(16);
    n_tests++;
    if (timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_clear: timeout=%b after accept, expected 0", timeout);
    end
    exp_q.push_back(16);
    while (exp_q.size() > 0) begin
      wait_duty_change(300, ok);
      e = exp_q.pop_front();
      n_tests++;
      if (!ok || duty_cur !== 8'(e) || cyc != 2400) begin
        n_fail++;
        $display("FAIL wd_resume_duty: got %0d at cyc %0d, expected %0d at cyc 2400", duty_cur, cyc, e);
      end
    end
  endtask

  task automatic test_enable_drop();
    bit ok; int e;
    do_reset();
    send_cmd(64);
    exp_q.push_back(16); exp_q.push_back(32); exp_q.push_back(48); exp_q.push_back(64);
    while (exp_q.size() > 0) begin
      wait_duty_change(300, ok);
      e = exp_q.pop_front();
      n_tests++;
      if (!ok || duty_cur !== 8'(e)) begin
        n_fail++;
        $display("FAIL en_up_duty: got %0d at cyc %0d, expected %0d", duty_cur, cyc, e);
      end
    end
    wait_until_cyc(510);
    n_tests++;
    if (pwm_out !== 1'b1) begin
      n_fail++;
      $display("FAIL en_pre_pwm: pwm=%b at counter 10, expected 1", pwm_out);
    end
    enable = 1'b0;
    @(negedge clk_100M);
    n_tests++;
    if (pwm_out !== 1'b0 || duty_cur !== 8'sd0) begin
      n_fail++;
      $display("FAIL en_drop: pwm=%b duty=%0d, expected 0 0", pwm_out, duty_cur);
    end
    wait_until_cyc(650);
    n_tests++;
    if (duty_cur !== 8'sd0 || pwm_out !== 1'b0 || dir_out !== 1'b0) begin
      n_fail++;
      $display("FAIL en_hold: duty=%0d pwm=%b dir=%b, expected 0 0 0", duty_cur, pwm_out, dir_out);
    end
    enable = 1'b1;
    exp_q.push_back(16);
    while (exp_q.size() > 0) begin
      wait_duty_change(300, ok);
      e = exp_q.pop_front();
      n_tests++;
      if (!ok || duty_cur !== 8'(e) || cyc != 700) begin
        n_fail++;
        $display("FAIL en_restart_duty: got %0d at cyc %0d, expected %0d at cyc 700", duty_cur, cyc, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok; int e;
    do_reset();
    send_cmd(64);
    send_cmd(16);
    exp_q.push_back(16);
    while (exp_q.size() > 0) begin
      wait_duty_change(300, ok);
      e = exp_q.pop_front();
      n_tests++;
      if (!ok || duty_cur !== 8'(e) || cyc != 100) begin
        n_fail++;
        $display("FAIL b2b_duty: got %0d at cyc %0d, expected %0d at cyc 100", duty_cur, cyc, e);
      end
    end
    wait_until_cyc(450);
    n_tests++;
    if (duty_cur !== 8'sd16) begin
      n_fail++;
      $display("FAIL b2b_hold: duty=%0d, expected 16", duty_cur);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    send_cmd(64);
    wait_until_cyc(305);
    n_tests++;
    if (pwm_out !== 1'b1 || duty_cur !== 8'sd48) begin
      n_fail++;
      $display("FAIL arst_pre: pwm=%b duty=%0d, expected 1 48", pwm_out, duty_cur);
    end
    #2;
    sysrstn = 1'b0;
    #1;
    n_tests++;
    if (pwm_out !== 1'b0 || duty_cur !== 8'sd0 || dir_out !== 1'b0 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_mid: pwm=%b duty=%0d dir=%b timeout=%b, expected all 0",
               pwm_out, duty_cur, dir_out, timeout);
    end
    @(negedge clk_100M);
    sysrstn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_reversal();
    test_clamp();
    test_watchdog();
    test_enable_drop();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
